operand_scan_ctrl: RTL and testbench
====================================

# operand_scan_ctrl

Upstream feeder for the seven-segment decoder in the FF/display/math lab design. It captures two 4-bit operands from the switches on debounced button presses and registers their modulo-16 sum and difference. It also generates the rotating active-low anode pattern that selects which value the decoder shows. Its outputs connect directly to the decoder's A, B, AplusB, AminusB and anode inputs.

## Interface
- REFRESH_DIV, 100000: clock cycles each digit is lit per scan slot; minimum 2.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a button level change; minimum 1.
- BLANK_CYCLES, 1000: all-off cycles between digits; used only with SCAN_BLANK_EN; minimum 1.
- clk  input  1  system clock; the only clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- sw  input  4  operand value from slide switches; asynchronous to clk.
- btn_load_a  input  1  raw push-button, high = pressed; loads A.
- btn_load_b  input  1  raw push-button, high = pressed; loads B.
- A  output  4  captured operand A.
- B  output  4  captured operand B.
- AplusB  output  4  (A + B) mod 16, registered.
- AminusB  output  4  (A - B) mod 16, two's complement, registered.
- anode  output  4  active-low digit select: 4'b1110 = A digit, 4'b1101 = B, 4'b1011 = sum, 4'b0111 = difference.

## Operation
- Button path, one per button, identical and independent:
  - 2-flop synchronizer.
  - Debounce counter runs while the synchronized level differs from the accepted level. Any cycle where they match clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES, the accepted level takes the synchronized value and the counter clears.
  - A 0->1 transition of the accepted level produces a one-cycle registered load pulse.
  - Releases (1->0) produce no pulse.
- Load:
  - On a load_a pulse, A <= sw at the next edge. On a load_b pulse, B <= sw at the next edge.
  - sw passes through a 2-flop synchronizer before capture.
  - Simultaneous pulses load both A and B from the same sw sample.
  - Holding a button produces exactly one load. sw changes while the button is held are ignored.
- Arithmetic:
  - AplusB and AminusB are recomputed from the registered A and B every cycle and registered.
  - They lag A and B by one cycle.
  - Results are 4 bits. Carry and borrow are discarded.
- Scan FSM:
  - States are DIG0..DIG3, driving anode 1110, 1101, 1011, 0111 respectively.
  - A prescale counter runs 0..REFRESH_DIV-1. At terminal count the counter wraps to 0 and the state advances DIG0 -> DIG1 -> DIG2 -> DIG3 -> DIG0.
  - Exactly one anode bit is low at any time (except during blanking, see Configuration).
  - Scan runs continuously and is unaffected by loads.

## Timing
- Reset values, applied immediately on rst_n low and held while it stays low:
  - A, B, AplusB, AminusB = 4'h0; anode = 4'b1110.
  - Synchronizers, accepted levels, debounce and prescale counters all = 0.
- Reset mid-operation (during debounce, a load, or any scan slot):
  - All state returns to its reset value.
  - A pending load is discarded.
  - A button held through reset release is accepted as a new press after the normal debounce latency.
- Press-to-A latency: the button is first sampled high at edge 1 and held. A shows sw at edge DEBOUNCE_CYCLES+4.
  - Edges 1-2: synchronizer.
  - Next DEBOUNCE_CYCLES edges: debounce counter.
  - One edge: pulse register.
  - One edge: A register.
- AplusB and AminusB are valid one edge after A or B changes.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles causes no load.
- Scan period is 4*REFRESH_DIV cycles. After reset, DIG0 lasts exactly REFRESH_DIV cycles.

## Configuration
- SCAN_BLANK_EN defined:
  - After each digit's REFRESH_DIV cycles, anode = 4'b1111 for BLANK_CYCLES cycles, then the next digit is lit.
  - Blanking suppresses ghosting between digits.
  - Scan period is 4*(REFRESH_DIV+BLANK_CYCLES).
  - Reset enters DIG0 lit, not blank.
- SCAN_BLANK_EN undefined:
  - No blank states; anode is never 4'b1111.
  - The BLANK_CYCLES parameter is ignored.

## Test plan
- Reset check, with REFRESH_DIV=4, DEBOUNCE_CYCLES=3:
  - Stimulus: assert rst_n low mid-slot DIG2.
  - Response: anode = 1110 and all data outputs 0 immediately. After release, anode goes 1110 x4, 1101 x4, 1011 x4, 0111 x4, then repeats.
- Operand load:
  - Stimulus: sw=4'h3, press A held; then sw=4'h5, press B held.
  - Response: A=3 at edge 7 after the press (DEBOUNCE_CYCLES+4), then B=5, AplusB=8, AminusB=4'hE. Each load occurs exactly once per press.
- Bounce rejection:
  - Stimulus: btn_load_a toggles every 2 cycles for 20 cycles, then stays low.
  - Response: A unchanged and no load pulse.
- Simultaneous load and wrap:
  - Stimulus: sw=4'hF, both buttons pressed in the same cycle.
  - Response: A=B=F, AplusB=4'hE, AminusB=4'h0.
- Blanking, with SCAN_BLANK_EN defined and BLANK_CYCLES=2:
  - Response: the sequence per slot is digit x4 then 1111 x2, giving a period of 24 cycles. Never more than one anode bit is low.

Source files
------------

// File: rtl/operand_scan_ctrl_if.sv
// rtl/operand_scan_ctrl_if.sv - switch/button inputs and decoder-facing outputs of operand_scan_ctrl
interface operand_scan_ctrl_if;
    logic [3:0] sw;
    logic       btn_load_a;
    logic       btn_load_b;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] AplusB;
    logic [3:0] AminusB;
    logic [3:0] anode;

    modport master (
        output sw, btn_load_a, btn_load_b,
        input  A, B, AplusB, AminusB, anode
    );

    modport slave (
        input  sw, btn_load_a, btn_load_b,
        output A, B, AplusB, AminusB, anode
    );
endinterface

// File: rtl/operand_scan_ctrl.sv
// rtl/operand_scan_ctrl.sv - operand capture, mod-16 sum/difference and anode scan for the 7-seg decoder
// Optional inter-digit blanking is enabled by defining SCAN_BLANK_EN.
module operand_scan_ctrl #(
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLANK_CYCLES    = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    operand_scan_ctrl_if.slave bus
);

    localparam int              DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]   DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
`ifdef SCAN_BLANK_EN
    localparam int              PMAX    = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
`else
    localparam int              PMAX    = REFRESH_DIV;
`endif
    localparam int              PW      = $clog2(PMAX);
    localparam logic [PW-1:0]   REF_LAST = PW'(REFRESH_DIV - 1);

    localparam logic [1:0] DIG0 = 2'd0;
    localparam logic [1:0] DIG1 = 2'd1;
    localparam logic [1:0] DIG2 = 2'd2;
    localparam logic [1:0] DIG3 = 2'd3;

    // Index 0 is the A button, index 1 the B button.
    logic [1:0]    btn_raw;
    logic [1:0]    bs1_q, bs2_q;
    logic [1:0]    acc_q, acc_d;
    logic [1:0]    acc_dly_q;
    logic [1:0]    pulse_q;
    logic [DW-1:0] db_cnt_q [0:1];
    logic [DW-1:0] db_cnt_d [0:1];

    logic [3:0]    sw_s1_q, sw_s2_q;
    logic [3:0]    a_q, a_d, b_q, b_d;
    logic [3:0]    sum_q, diff_q;

    logic [1:0]    state_q, state_d, state_nxt;
    logic [PW-1:0] pre_q, pre_d;
    logic          blank_q, blank_d;

    assign btn_raw = {bus.btn_load_b, bus.btn_load_a};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            acc_d[i]    = acc_q[i];
            db_cnt_d[i] = '0;
            if (bs2_q[i] != acc_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    acc_d[i] = bs2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (pulse_q[0]) a_d = sw_s2_q;
        if (pulse_q[1]) b_d = sw_s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bs1_q       <= '0;
            bs2_q       <= '0;
            acc_q       <= '0;
            acc_dly_q   <= '0;
            pulse_q     <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            diff_q      <= '0;
        end else begin
            bs1_q       <= btn_raw;
            bs2_q       <= bs1_q;
            acc_q       <= acc_d;
            acc_dly_q   <= acc_q;
            // Rising edge of the accepted level only; releases never load.
            pulse_q     <= acc_q & ~acc_dly_q;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            sw_s1_q     <= bus.sw;
            sw_s2_q     <= sw_s1_q;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= a_q + b_q;
            diff_q      <= a_q - b_q;
        end
    end

    always_comb begin
        case (state_q)
            DIG0:    state_nxt = DIG1;
            DIG1:    state_nxt = DIG2;
            DIG2:    state_nxt = DIG3;
            default: state_nxt = DIG0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q + PW'(1);
        blank_d = 1'b0;
`ifdef SCAN_BLANK_EN
        blank_d = blank_q;
        if (blank_q) begin
            if (pre_q == PW'(BLANK_CYCLES - 1)) begin
                pre_d   = '0;
                blank_d = 1'b0;
                state_d = state_nxt;
            end
        end else if (pre_q == REF_LAST) begin
            pre_d   = '0;
            blank_d = 1'b1;
        end
`else
        if (pre_q == REF_LAST) begin
            pre_d   = '0;
            state_d = state_nxt;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIG0;
            pre_q   <= '0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            blank_q <= blank_d;
        end
    end

    // Anode decodes straight from state so reset shows DIG0 without waiting for an edge.
    always_comb begin
        case (state_q)
            DIG0:    bus.anode = 4'b1110;
            DIG1:    bus.anode = 4'b1101;
            DIG2:    bus.anode = 4'b1011;
            default: bus.anode = 4'b0111;
        endcase
        if (blank_q) bus.anode = 4'b1111;
    end

    assign bus.A       = a_q;
    assign bus.B       = b_q;
    assign bus.AplusB  = sum_q;
    assign bus.AminusB = diff_q;

endmodule

// File: tb/tb_operand_scan_ctrl.sv
// tb/tb_operand_scan_ctrl.sv - self-checking bench for operand_scan_ctrl (build with or without SCAN_BLANK_EN)
module tb_operand_scan_ctrl;

    localparam int RD = 4;
    localparam int DB = 3;
    localparam int BL = 2;
`ifdef SCAN_BLANK_EN
    localparam int SLOT = RD + BL;
`else
    localparam int SLOT = RD;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    operand_scan_ctrl_if bus();

    operand_scan_ctrl #(
        .REFRESH_DIV    (RD),
        .DEBOUNCE_CYCLES(DB),
        .BLANK_CYCLES   (BL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: edges counted since reset release; a press is a raw level held for DB
    // samples, which loads the sw value sampled two edges later, four edges later.
    int         n;
    logic [3:0] mA, mB, mS, mD;
    logic       m_acc [0:1];
    int         m_run [0:1];
    logic [3:0] sw_hist [0:4095];
    logic [1:0] ld_at   [0:4095];
    int         src_at  [0:4095];
    logic [1:0] btn;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            mA = 4'h0; mB = 4'h0; mS = 4'h0; mD = 4'h0;
            for (int i = 0; i < 2; i++) begin
                m_acc[i] = 1'b0;
                m_run[i] = 0;
            end
            for (int k = 0; k < 4096; k++) begin
                ld_at[k]  = 2'b00;
                src_at[k] = 0;
                sw_hist[k] = 4'h0;
            end
        end else begin
            n = n + 1;
            sw_hist[n % 4096] = bus.sw;
            mS = mA + mB;
            mD = mA - mB;
            btn = {bus.btn_load_b, bus.btn_load_a};
            for (int i = 0; i < 2; i++) begin
                if (btn[i] != m_acc[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DB) begin
                        m_acc[i] = btn[i];
                        m_run[i] = 0;
                        if (btn[i]) begin
                            ld_at[(n + 4) % 4096][i] = 1'b1;
                            src_at[(n + 4) % 4096]   = n + 2;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            if (ld_at[n % 4096][0]) mA = sw_hist[src_at[n % 4096] % 4096];
            if (ld_at[n % 4096][1]) mB = sw_hist[src_at[n % 4096] % 4096];
            ld_at[n % 4096] = 2'b00;
        end
    end

    function automatic logic [3:0] model_anode();
        logic [3:0] one;
        int off, dig;
        one = 4'b0001;
        off = n % SLOT;
        dig = (n / SLOT) % 4;
        if (off < RD) return ~(one << dig);
        return 4'b1111;
    endfunction

    always @(negedge clk) begin
        check4("cyc_A",       bus.A,       mA);
        check4("cyc_B",       bus.B,       mB);
        check4("cyc_AplusB",  bus.AplusB,  mS);
        check4("cyc_AminusB", bus.AminusB, mD);
        check4("cyc_anode",   bus.anode,   model_anode());
        n_checks++;
        if ($countones(~bus.anode) > 1) begin
            n_fail++;
            $display("FAIL anode_onehot: got %b, expected at most one low bit", bus.anode);
        end
    end

    logic [3:0] exp_tab [0:23];

    initial begin
`ifdef SCAN_BLANK_EN
        for (int k = 0; k < 24; k++) begin
            if ((k % 6) >= 4)       exp_tab[k] = 4'b1111;
            else if (k < 6)         exp_tab[k] = 4'b1110;
            else if (k < 12)        exp_tab[k] = 4'b1101;
            else if (k < 18)        exp_tab[k] = 4'b1011;
            else                    exp_tab[k] = 4'b0111;
        end
`else
        for (int k = 0; k < 24; k++) begin
            case ((k / 4) % 4)
                0:       exp_tab[k] = 4'b1110;
                1:       exp_tab[k] = 4'b1101;
                2:       exp_tab[k] = 4'b1011;
                default: exp_tab[k] = 4'b0111;
            endcase
        end
`endif
        bus.sw = 4'h0;
        bus.btn_load_a = 1'b0;
        bus.btn_load_b = 1'b0;
        repeat (3) @(negedge clk);
        check4("rst_A",     bus.A,       4'h0);
        check4("rst_sum",   bus.AplusB,  4'h0);
        check4("rst_anode", bus.anode,   4'b1110);
        rst_n = 1'b1;

        @(negedge clk);
        bus.sw = 4'h3;
        bus.btn_load_a = 1'b1;
        repeat (6) @(posedge clk);
        #1 check4("lat_A_edge6", bus.A, 4'h0);
        @(posedge clk);
        #1 check4("lat_A_edge7", bus.A, 4'h3);
        @(negedge clk);
        bus.sw = 4'h9;
        repeat (10) @(negedge clk);
        bus.btn_load_a = 1'b0;
        repeat (8) @(negedge clk);
        check4("hold_once_A", bus.A, 4'h3);

        bus.sw = 4'h5;
        bus.btn_load_b = 1'b1;
        repeat (12) @(negedge clk);
        check4("load_B",   bus.B,       4'h5);
        check4("sum_3_5",  bus.AplusB,  4'h8);
        check4("diff_3_5", bus.AminusB, 4'hE);
        bus.btn_load_b = 1'b0;
        repeat (8) @(negedge clk);

        bus.sw = 4'h7;
        for (int i = 0; i < 10; i++) begin
            bus.btn_load_a = ~bus.btn_load_a;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check4("bounce_A", bus.A, 4'h3);

        bus.sw = 4'hF;
        bus.btn_load_a = 1'b1;
        bus.btn_load_b = 1'b1;
        repeat (12) @(negedge clk);
        check4("both_A",    bus.A,       4'hF);
        check4("both_B",    bus.B,       4'hF);
        check4("both_sum",  bus.AplusB,  4'hE);
        check4("both_diff", bus.AminusB, 4'h0);
        bus.btn_load_a = 1'b0;
        bus.btn_load_b = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 40 && !((n % SLOT) == 1 && ((n / SLOT) % 4) == 2); i++)
            @(negedge clk);
        n_checks++;
        if (!((n % SLOT) == 1 && ((n / SLOT) % 4) == 2)) begin
            n_fail++;
            $display("FAIL find_dig2: slot search timed out at n=%0d", n);
        end
        check4("pre_rst_dig2", bus.anode, 4'b1011);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check4("midrst_anode", bus.anode,   4'b1110);
        check4("midrst_A",     bus.A,       4'h0);
        check4("midrst_B",     bus.B,       4'h0);
        check4("midrst_sum",   bus.AplusB,  4'h0);
        check4("midrst_diff",  bus.AminusB, 4'h0);
        bus.sw = 4'h6;
        bus.btn_load_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check4("scan_0", bus.anode, exp_tab[0]);
        for (int k = 1; k < 24; k++) begin
            @(posedge clk);
            #1 check4($sformatf("scan_%0d", k), bus.anode, exp_tab[k]);
        end
        repeat (4) @(negedge clk);
        check4("held_thru_rst_A", bus.A, 4'h6);
        bus.btn_load_a = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
